// File: rtl/rx78_busctl.sv
// RX-78 bus controller: memory-map decode, one-cycle read-data mux,
// VRAM plane select/write-mask I/O registers and vblank interrupt.
module rx78_busctl #(
    parameter int          NUM_PLANES = 6,
    parameter logic [15:0] CART_BASE  = 16'h2000,
    parameter logic [15:0] EXT_BASE   = 16'h6000,
    parameter logic [15:0] RAM_BASE   = 16'hB000,
    parameter logic [15:0] VRAM_BASE  = 16'hEC00,
    parameter logic [7:0]  IO_BASE    = 8'hF0,
    localparam int         PW         = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cen,
    input  logic [15:0]           addr,
    input  logic [7:0]            cpu_do,
    input  logic                  mreq_n,
    input  logic                  iorq_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic                  m1_n,
    input  logic                  vb,
    output logic [7:0]            cpu_di,
    output logic                  int_n,
    output logic                  rom_cs,
    output logic                  cart_cs,
    output logic                  ext_cs,
    output logic                  ram_cs,
    output logic                  vram_cs,
    output logic                  mem_wr,
    output logic [NUM_PLANES-1:0] vram_we,
    output logic [PW-1:0]         vram_plane,
    input  logic [7:0]            rom_q,
    input  logic [7:0]            cart_q,
    input  logic [7:0]            ext_q,
    input  logic [7:0]            ram_q,
    input  logic [7:0]            vram_q
);

    // Bit positions in the registered one-hot source vector.
    localparam int SEL_ROM  = 0;
    localparam int SEL_CART = 1;
    localparam int SEL_EXT  = 2;
    localparam int SEL_RAM  = 3;
    localparam int SEL_VRAM = 4;
    localparam int SEL_IO   = 5;

    localparam logic [7:0]    PORT_PLANE = IO_BASE + 8'd1;
    localparam logic [7:0]    PORT_MASK  = IO_BASE + 8'd2;
    localparam logic [7:0]    PORT_CTRL  = IO_BASE + 8'd3;
    localparam logic [PW-1:0] PLANE_MAX  = PW'(NUM_PLANES - 1);

    logic [PW-1:0]         r_plane;
    logic [NUM_PLANES-1:0] r_wmask;
    logic                  r_int_en;
    logic                  r_pending;
    logic                  r_vb_d;
    logic [5:0]            r_sel_q;
    logic [7:0]            r_io_q;

    logic       w_rom, w_cart, w_ext, w_ram, w_vram;
    logic       w_io_cyc, w_io_wr, w_ack, w_rise, w_clr;
    logic [7:0] w_port;
    logic [7:0] w_io_rd;
    logic [5:0] w_sel_d;
    logic       w_unused;

    // Half-open address windows; exactly one is true for any address.
    assign w_rom  = (addr < CART_BASE);
    assign w_cart = (addr >= CART_BASE) && (addr < EXT_BASE);
    assign w_ext  = (addr >= EXT_BASE)  && (addr < RAM_BASE);
    assign w_ram  = (addr >= RAM_BASE)  && (addr < VRAM_BASE);
    assign w_vram = (addr >= VRAM_BASE);

    assign rom_cs  = ~mreq_n & w_rom;
    assign cart_cs = ~mreq_n & w_cart;
    assign ext_cs  = ~mreq_n & w_ext;
    assign ram_cs  = ~mreq_n & w_ram;
    assign vram_cs = ~mreq_n & w_vram;
    assign mem_wr  = ~mreq_n & ~wr_n;

    assign vram_we    = {NUM_PLANES{mem_wr & vram_cs}} & r_wmask;
    assign vram_plane = (r_plane > PLANE_MAX) ? PLANE_MAX : r_plane;

    assign w_port   = addr[7:0];
    assign w_io_cyc = ~iorq_n & m1_n;
    assign w_io_wr  = cen & w_io_cyc & ~wr_n;
    assign w_ack    = cen & ~iorq_n & ~m1_n;
    assign w_rise   = vb & ~r_vb_d;
    assign w_clr    = w_ack | (w_io_wr & (w_port == PORT_CTRL) & cpu_do[1]);

    assign int_n    = ~(r_pending & r_int_en);

    // rd_n is not needed: the mux latches every selected cycle.
    assign w_unused = ^{rd_n, cpu_do};

    always_comb begin
        w_sel_d = '0;
        if (!mreq_n) begin
            w_sel_d[SEL_ROM]  = w_rom;
            w_sel_d[SEL_CART] = w_cart;
            w_sel_d[SEL_EXT]  = w_ext;
            w_sel_d[SEL_RAM]  = w_ram;
            w_sel_d[SEL_VRAM] = w_vram;
        end else if (w_io_cyc) begin
            w_sel_d[SEL_IO]   = 1'b1;
        end
    end

    always_comb begin
        w_io_rd = 8'hFF;
        if (w_port == PORT_PLANE)
            w_io_rd = 8'(r_plane);
        else if (w_port == PORT_MASK)
            w_io_rd = 8'(r_wmask);
        else if (w_port == PORT_CTRL)
            w_io_rd = {6'b0, r_pending, r_int_en};
    end

    // Source data is taken from the live bus one cycle after the select.
    always_comb begin
        cpu_di = 8'hFF;
        if (r_sel_q[SEL_ROM])       cpu_di = rom_q;
        else if (r_sel_q[SEL_CART]) cpu_di = cart_q;
        else if (r_sel_q[SEL_EXT])  cpu_di = ext_q;
        else if (r_sel_q[SEL_RAM])  cpu_di = ram_q;
        else if (r_sel_q[SEL_VRAM]) cpu_di = vram_q;
        else if (r_sel_q[SEL_IO])   cpu_di = r_io_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q <= '0;
            r_io_q  <= 8'hFF;
        end else if (cen) begin
            r_sel_q <= w_sel_d;
            r_io_q  <= w_io_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_plane  <= '0;
            r_wmask  <= '1;
            r_int_en <= 1'b1;
        end else if (w_io_wr) begin
            if (w_port == PORT_PLANE) r_plane  <= cpu_do[PW-1:0];
            if (w_port == PORT_MASK)  r_wmask  <= cpu_do[NUM_PLANES-1:0];
            if (w_port == PORT_CTRL)  r_int_en <= cpu_do[0];
        end
    end

    // A new vblank edge beats a simultaneous acknowledge/clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_vb_d    <= vb;
        end else if (cen) begin
            r_vb_d <= vb;
            if (w_rise)
                r_pending <= 1'b1;
            else if (w_clr)
                r_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx78_busctl.sv
// Self-checking bench for rx78_busctl: directed scenarios plus randomized
// bus traffic compared every cycle against a behavioural model.
module tb_rx78_busctl;

    logic        clk = 1'b0;
    logic        reset, cen;
    logic [15:0] addr;
    logic [7:0]  cpu_do;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, vb;
    logic [7:0]  cpu_di;
    logic        int_n;
    logic        rom_cs, cart_cs, ext_cs, ram_cs, vram_cs, mem_wr;
    logic [5:0]  vram_we;
    logic [2:0]  vram_plane;
    logic [7:0]  rom_q, cart_q, ext_q, ram_q, vram_q;

    rx78_busctl dut (
        .clk(clk), .reset(reset), .cen(cen), .addr(addr), .cpu_do(cpu_do),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .vb(vb), .cpu_di(cpu_di), .int_n(int_n),
        .rom_cs(rom_cs), .cart_cs(cart_cs), .ext_cs(ext_cs), .ram_cs(ram_cs),
        .vram_cs(vram_cs), .mem_wr(mem_wr), .vram_we(vram_we),
        .vram_plane(vram_plane),
        .rom_q(rom_q), .cart_q(cart_q), .ext_q(ext_q), .ram_q(ram_q),
        .vram_q(vram_q)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    bit hold_q = 0;

    // Model state: sources are 0 none, 1 rom, 2 cart, 3 ext, 4 ram, 5 vram, 6 io.
    int         m_plane;
    logic [5:0] m_wmask;
    bit         m_inen, m_pend, m_vbd;
    int         m_sel;
    logic [7:0] m_io;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int region(input logic [15:0] a);
        if (a < 16'h2000) return 1;
        if (a < 16'h6000) return 2;
        if (a < 16'hB000) return 3;
        if (a < 16'hEC00) return 4;
        return 5;
    endfunction

    function automatic logic [7:0] ioread(input logic [7:0] p);
        case (p)
            8'hF1:   return 8'(m_plane);
            8'hF2:   return {2'b00, m_wmask};
            8'hF3:   return {6'b0, m_pend, m_inen};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check_outputs();
        logic [4:0] exp_cs;
        logic [7:0] exp_di;
        int r;
        r = region(addr);
        exp_cs = mreq_n ? 5'b0 : 5'(1 << (r - 1));
        chk("cs", {vram_cs, ram_cs, ext_cs, cart_cs, rom_cs}, 32'(exp_cs));
        chk("mem_wr", mem_wr, 32'(!mreq_n && !wr_n));
        chk("vram_we", vram_we, (!mreq_n && !wr_n && r == 5) ? 32'(m_wmask) : 32'd0);
        chk("plane", vram_plane, (m_plane > 5) ? 32'd5 : 32'(m_plane));
        chk("int_n", int_n, 32'(!(m_pend && m_inen)));
        case (m_sel)
            1: exp_di = rom_q;
            2: exp_di = cart_q;
            3: exp_di = ext_q;
            4: exp_di = ram_q;
            5: exp_di = vram_q;
            6: exp_di = m_io;
            default: exp_di = 8'hFF;
        endcase
        chk("cpu_di", cpu_di, 32'(exp_di));
    endtask

    task automatic model_update();
        logic [7:0] p;
        bit rise, clr;
        if (reset) begin
            m_plane = 0; m_wmask = 6'h3F; m_inen = 1; m_pend = 0;
            m_vbd = vb; m_sel = 0; m_io = 8'hFF;
            return;
        end
        if (!cen) return;
        p = addr[7:0];
        m_io = ioread(p);
        m_sel = !mreq_n ? region(addr) : (!iorq_n && m1_n) ? 6 : 0;
        clr = 0;
        if (!iorq_n && !wr_n && m1_n) begin
            if (p == 8'hF1) m_plane = int'(cpu_do) % 8;
            if (p == 8'hF2) m_wmask = cpu_do[5:0];
            if (p == 8'hF3) begin
                m_inen = cpu_do[0];
                clr = cpu_do[1];
            end
        end
        if (!iorq_n && !m1_n) clr = 1;
        rise = vb && !m_vbd;
        if (rise) m_pend = 1;
        else if (clr) m_pend = 0;
        m_vbd = vb;
    endtask

    // Called at posedge+1 with inputs applied; returns at next posedge+1.
    task automatic cyc();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit mq, iq, rd, wr, m1, input logic [15:0] a, input logic [7:0] d);
        mreq_n = mq; iorq_n = iq; rd_n = rd; wr_n = wr; m1_n = m1;
        addr = a; cpu_do = d;
        if (!hold_q) begin
            rom_q = 8'($urandom); cart_q = 8'($urandom); ext_q = 8'($urandom);
            ram_q = 8'($urandom); vram_q = 8'($urandom);
        end
        cyc();
    endtask

    task automatic idle();           bus(1, 1, 1, 1, 1, 16'h0000, 8'h00); endtask
    task automatic mrd(input logic [15:0] a); bus(0, 1, 0, 1, 1, a, 8'h00); endtask
    task automatic mwr(input logic [15:0] a, input logic [7:0] d); bus(0, 1, 1, 0, 1, a, d); endtask
    task automatic ior(input logic [7:0] p); bus(1, 0, 0, 1, 1, {8'h00, p}, 8'h00); endtask
    task automatic iow(input logic [7:0] p, input logic [7:0] d); bus(1, 0, 1, 0, 1, {8'h00, p}, d); endtask
    task automatic ack();            bus(1, 0, 1, 1, 0, 16'h0038, 8'h00); endtask

    logic [15:0] bnd [9] = '{16'h1FFF, 16'h2000, 16'h5FFF, 16'h6000, 16'hAFFF,
                             16'hB000, 16'hEBFF, 16'hEC00, 16'hFFFF};
    int          bnd_r [9] = '{1, 2, 2, 3, 3, 4, 4, 5, 5};

    initial begin
        logic [15:0] a;
        logic [7:0]  p;
        reset = 1; cen = 1; vb = 0;
        mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1;
        addr = 0; cpu_do = 0;
        rom_q = 0; cart_q = 0; ext_q = 0; ram_q = 0; vram_q = 0;
        @(posedge clk);
        #1;
        model_update();
        chk("rst_di", cpu_di, 32'hFF);
        chk("rst_int", int_n, 32'd1);
        chk("rst_plane", vram_plane, 32'd0);
        idle();
        reset = 0;

        // Decode boundaries, explicit region per address, then mreq_n high.
        for (int i = 0; i < 9; i++) begin
            addr = bnd[i]; mreq_n = 0;
            #1;
            chk("bnd_cs", {vram_cs, ram_cs, ext_cs, cart_cs, rom_cs}, 32'(1 << (bnd_r[i] - 1)));
            mrd(bnd[i]);
        end
        for (int i = 0; i < 9; i++) bus(1, 1, 0, 1, 1, bnd[i], 8'h00);

        // Read latency.
        hold_q = 1;
        rom_q = 8'hA5; ram_q = 8'h3C;
        mrd(16'h0010);
        chk("lat_rom", cpu_di, 32'hA5);
        mrd(16'hC000);
        chk("lat_ram", cpu_di, 32'h3C);
        ior(8'hF0);
        chk("io_f0", cpu_di, 32'hFF);
        hold_q = 0;
        idle();

        // Plane mask and plane select.
        iow(8'hF2, 8'h05);
        mwr(16'hEC00, 8'h77);
        idle();
        iow(8'hF1, 8'h07);
        ior(8'hF1);
        chk("plane_rd7", cpu_di, 32'h07);
        chk("plane_sat", vram_plane, 32'd5);
        iow(8'hF1, 8'h09);
        ior(8'hF1);
        chk("plane_rd9", cpu_di, 32'h01);
        cen = 0;
        iow(8'hF1, 8'h04);
        cen = 1;
        chk("cen_hold", vram_plane, 32'd1);

        // Interrupt set, readback, acknowledge, no re-assert while vb high.
        vb = 1;
        idle();
        chk("int_set", int_n, 32'd0);
        ior(8'hF3);
        chk("ctrl_rd", cpu_di, 32'h03);
        ack();
        chk("int_ack", int_n, 32'd1);
        idle(); idle();
        chk("int_hold", int_n, 32'd1);

        // Rising edge and clear in the same cycle: set wins.
        vb = 0;
        idle();
        vb = 1;
        iow(8'hF3, 8'h03);
        chk("set_wins", int_n, 32'd0);

        // Reset mid-operation with vb high.
        iow(8'hF2, 8'h00);
        reset = 1;
        idle();
        reset = 0;
        chk("rst_mid_int", int_n, 32'd1);
        ior(8'hF2);
        chk("rst_mask", cpu_di, 32'h3F);
        idle();
        chk("rst_no_edge", int_n, 32'd1);
        vb = 0;
        idle();
        vb = 1;
        idle();
        chk("rst_new_edge", int_n, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            cen = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 19) == 0) vb = ~vb;
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hEC00 + 16'($urandom_range(0, 5119));
            p = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hF0 + 8'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: bus(1, 1, 1, 1, 1, a, 8'($urandom));
                1: bus(0, 1, 0, 1, 1, a, 8'($urandom));
                2: bus(0, 1, 1, 0, 1, a, 8'($urandom));
                3: bus(1, 0, 0, 1, 1, {8'h12, p}, 8'($urandom));
                4: bus(1, 0, 1, 0, 1, {8'h12, p}, 8'($urandom));
                default: bus(1, 0, 1, 1, 0, a, 8'($urandom));
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
